// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: fetch queue entry layout and default geometry
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_queue_entry_t;
    localparam int FQ_DEPTH  = 8;
    localparam int FQ_IN_NUM = 2;
    localparam int FQ_DATA_W = $bits(fetch_queue_entry_t);
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: multi-push single-pop circular buffer between fetch and decode
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int IN_NUM = FQ_IN_NUM,
    parameter int DATA_W = FQ_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [IN_NUM-1:0]          in_valid,
    input  logic [IN_NUM*DATA_W-1:0]   in_data,
    output logic                       in_rdy,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    logic [PW-1:0] head, tail, k;
    logic [DATA_W-1:0] mem [DEPTH];
    logic push, pop;
    always_comb begin
        k = '0;
        for (int i = 0; i < IN_NUM; i++) k = k + PW'(in_valid[i]);
    end
    assign count     = tail - head;
    assign in_rdy    = !flush && (PW'(DEPTH) - count) >= PW'(IN_NUM);
    assign out_valid = !flush && count != '0;
    assign out_data  = mem[head[AW-1:0]];
    assign push      = in_rdy && |in_valid;
    assign pop       = out_valid && out_rdy;
    // storage is intentionally unreset; pointers alone define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_NUM; i++)
            if (push && in_valid[i]) mem[tail[AW-1:0] + AW'(i)] <= in_data[i*DATA_W +: DATA_W];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            tail <= push ? tail + k : tail;
            head <= pop ? head + PW'(1) : head;
        end
    end
    a_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid & (in_valid + IN_NUM'(1))) == '0);
endmodule
